// File: rtl/arb_pkg.sv
// Shared constants and types for the two-port data-memory arbiter.
package arb_pkg;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    localparam int LOCK_MAX_DEFAULT = 8;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_P0   = 2'd1,
        OWN_P1   = 2'd2
    } lock_owner_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side request/response bundle; one instance per arbiter port.
interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          valid;
    logic          ready;
    logic          we;
    logic          lock;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [3:0]    be;
    logic          rsp_valid;
    logic [DW-1:0] rdata;

    modport master (
        output valid, we, lock, addr, wdata, be,
        input  ready, rsp_valid, rdata
    );

    modport slave (
        input  valid, we, lock, addr, wdata, be,
        output ready, rsp_valid, rdata
    );
endinterface

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational one-hot grant selection: forced switch, then lock owner, then round-robin.
// ARB_FIXED_PRIO_EN makes port 0 win every tie instead of alternating.
module arb_rr_pick
    import arb_pkg::*;
(
    input  logic        valid0,
    input  logic        valid1,
    input  logic        last_grant,
    input  lock_owner_e lock_owner,
    input  logic        force_switch,
    output logic [1:0]  grant
);

    // Grant priority: forced hand-over, lock retention, tie break, single requester
    always_comb begin
        grant = 2'b00;
        if (force_switch) begin
            grant = (lock_owner == OWN_P0) ? {valid1, 1'b0} : {1'b0, valid0};
        end else if ((lock_owner == OWN_P0) && valid0) begin
            grant = 2'b01;
        end else if ((lock_owner == OWN_P1) && valid1) begin
            grant = 2'b10;
        end else if (valid0 && valid1) begin
`ifdef ARB_FIXED_PRIO_EN
            grant = 2'b01;
`else
            grant = (last_grant == PORT_CPU) ? 2'b10 : 2'b01;
`endif
        end else if (valid0) begin
            grant = 2'b01;
        end else if (valid1) begin
            grant = 2'b10;
        end else begin
            grant = 2'b00;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port data-memory arbiter with per-port lock and one-cycle response routing.
// ARB_FIXED_PRIO_EN: port 0 wins ties; only a port 1 lock is bounded by LOCK_MAX.
module mem_arbiter
    import arb_pkg::*;
#(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int LOCK_MAX = LOCK_MAX_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  p0,
    mem_arbiter_if.slave  p1,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic [3:0]    mem_be,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [7:0] LOCK_MAX_C = 8'(LOCK_MAX);

    logic        last_grant_q, last_grant_d;
    lock_owner_e lock_owner_q, lock_owner_d;
    logic [7:0]  lock_cnt_q,   lock_cnt_d;
    logic        rsp_pend_q,   rsp_pend_d;
    logic        rsp_owner_q,  rsp_owner_d;
    logic        rsp_rd_q,     rsp_rd_d;

    logic [1:0]  pick_grant_s;
    logic [1:0]  grant_s;
    logic        force_switch_s;
    logic        xfer_lock_s;
    lock_owner_e win_owner_s;
    logic [7:0]  base_cnt_s;

    // A lock that has used its budget yields as soon as the other port is waiting
    always_comb begin
        force_switch_s = 1'b0;
        if (lock_cnt_q == LOCK_MAX_C) begin
`ifdef ARB_FIXED_PRIO_EN
            force_switch_s = (lock_owner_q == OWN_P1) && p0.valid;
`else
            force_switch_s = ((lock_owner_q == OWN_P0) && p1.valid) ||
                             ((lock_owner_q == OWN_P1) && p0.valid);
`endif
        end else begin
            force_switch_s = 1'b0;
        end
    end

    arb_rr_pick u_pick (
        .valid0       (p0.valid),
        .valid1       (p1.valid),
        .last_grant   (last_grant_q),
        .lock_owner   (lock_owner_q),
        .force_switch (force_switch_s),
        .grant        (pick_grant_s)
    );

    // Grant is held off while reset is asserted so every output reads zero
    always_comb begin
        if (rst) begin
            grant_s = 2'b00;
        end else begin
            grant_s = pick_grant_s;
        end
    end

    assign p0.ready = grant_s[0];
    assign p1.ready = grant_s[1];

    // Winning request drives the memory port in its transfer cycle
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = 4'h0;
        if (grant_s[1]) begin
            mem_en    = 1'b1;
            mem_we    = p1.we;
            mem_addr  = p1.addr;
            mem_wdata = p1.wdata;
            mem_be    = p1.be;
        end else if (grant_s[0]) begin
            mem_en    = 1'b1;
            mem_we    = p0.we;
            mem_addr  = p0.addr;
            mem_wdata = p0.wdata;
            mem_be    = p0.be;
        end else begin
            mem_en = 1'b0;
        end
    end

    // Arbitration state: last winner, lock ownership and lock budget
    always_comb begin
        last_grant_d = last_grant_q;
        lock_owner_d = lock_owner_q;
        lock_cnt_d   = lock_cnt_q;
        xfer_lock_s  = grant_s[1] ? p1.lock : p0.lock;
        win_owner_s  = grant_s[1] ? OWN_P1 : OWN_P0;
        base_cnt_s   = force_switch_s ? 8'd0 : lock_cnt_q;
        if (grant_s != 2'b00) begin
            last_grant_d = grant_s[1];
            // A non-owner served while the owner is idle leaves the lock untouched
            if (force_switch_s || (lock_owner_q == OWN_NONE) || (lock_owner_q == win_owner_s)) begin
                if (xfer_lock_s) begin
                    lock_owner_d = win_owner_s;
                    lock_cnt_d   = (base_cnt_s >= LOCK_MAX_C) ? LOCK_MAX_C : base_cnt_s + 8'd1;
                end else begin
                    lock_owner_d = OWN_NONE;
                    lock_cnt_d   = 8'd0;
                end
            end else begin
                lock_owner_d = lock_owner_q;
            end
        end else begin
            last_grant_d = last_grant_q;
        end
    end

    // Remember who issued this cycle so the response returns to them next cycle
    always_comb begin
        rsp_pend_d  = grant_s[1] | grant_s[0];
        rsp_owner_d = grant_s[1];
        rsp_rd_d    = ~mem_we;
    end

    // Response routing; write responses carry zero data
    always_comb begin
        p0.rsp_valid = rsp_pend_q & ~rsp_owner_q;
        p1.rsp_valid = rsp_pend_q &  rsp_owner_q;
        p0.rdata     = (p0.rsp_valid && rsp_rd_q) ? mem_rdata : '0;
        p1.rdata     = (p1.rsp_valid && rsp_rd_q) ? mem_rdata : '0;
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= 1'b1;
            lock_owner_q <= OWN_NONE;
            lock_cnt_q   <= 8'd0;
            rsp_pend_q   <= 1'b0;
            rsp_owner_q  <= 1'b0;
            rsp_rd_q     <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            lock_owner_q <= lock_owner_d;
            lock_cnt_q   <= lock_cnt_d;
            rsp_pend_q   <= rsp_pend_d;
            rsp_owner_q  <= rsp_owner_d;
            rsp_rd_q     <= rsp_rd_d;
        end
    end

endmodule
